// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// Serial-to-parallel I2S receiver. SerialData and WS are launched on falling
// SCK by the transmitter and sampled here on rising SCK. One stereo frame
// {Left,Right} is delivered per WS period, with a one-cycle Valid strobe.
//
// Parameters
//   WIDTH       bits per channel word; the frame word is 2*WIDTH bits
//
// Ports
//   SCK         in   bit clock; all logic runs on posedge SCK
//   reset       in   synchronous, active-high reset
//   SerialData  in   serial data, MSB first
//   WS          in   word select: 0 = left, 1 = right
//   RxData      out  last complete frame {Left,Right}
//   LeftData    out  upper half of RxData
//   RightData   out  lower half of RxData
//   Valid       out  one-cycle pulse: new RxData available
//   Locked      out  1 once the first left-word boundary has been seen
//   FrameError  out  word-length error pulse (FRAME_ERR_EN builds only)
//
// Build option
//   FRAME_ERR_EN  when defined, every channel boundary after lock compares
//                 the number of bits received against WIDTH and pulses
//                 FrameError on a mismatch. When undefined, FrameError is 0.
// ---------------------------------------------------------------------------
module i2s_receiver #(
    parameter int WIDTH = 8
) (
    input  logic               SCK,
    input  logic               reset,
    input  logic               SerialData,
    input  logic               WS,
    output logic [2*WIDTH-1:0] RxData,
    output logic [WIDTH-1:0]   LeftData,
    output logic [WIDTH-1:0]   RightData,
    output logic               Valid,
    output logic               Locked,
    output logic               FrameError
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
`ifdef FRAME_ERR_EN
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t             state_q;
    logic               prevWs_q;
    logic [CW-1:0]      bitCnt_q;
    logic [CW-1:0]      bitCnt_d;
    logic [WIDTH-1:0]   word_q;
    logic [WIDTH-1:0]   word_d;
    logic [WIDTH-1:0]   leftHold_q;
    logic [2*WIDTH-1:0] rxData_q;
    logic               valid_q;
    logic               locked_q;
    logic               boundary;
`ifdef FRAME_ERR_EN
    logic               frameErr_q;
`endif

    // A WS change marks the edge carrying the previous channel's LSB.
    assign boundary = (WS != prevWs_q);

    // Word as it stands after this edge's bit has been shifted in. Bits are
    // placed MSB first; once WIDTH bits are in, further bits are dropped so
    // over-long words keep their most significant part.
    always_comb begin
        word_d   = word_q;
        bitCnt_d = bitCnt_q;
        if (bitCnt_q < CNT_FULL) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bitCnt_q == CW'(WIDTH - 1 - i)) begin
                    word_d[i] = SerialData;
                end
            end
            bitCnt_d = bitCnt_q + CW'(1);
        end
    end

    // Framing FSM. The boundary bit is captured into the finishing word
    // (word_d) before the shift register is cleared for the next channel.
    always_ff @(posedge SCK) begin
        if (reset) begin
            state_q    <= SYNC;
            prevWs_q   <= 1'b1;
            bitCnt_q   <= '0;
            word_q     <= '0;
            leftHold_q <= '0;
            rxData_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
`ifdef FRAME_ERR_EN
            frameErr_q <= 1'b0;
`endif
        end else begin
            prevWs_q <= WS;
            valid_q  <= 1'b0;

            if (boundary) begin
                word_q   <= '0;
                bitCnt_q <= '0;
            end else begin
                word_q   <= word_d;
                bitCnt_q <= bitCnt_d;
            end

            case (state_q)
                SYNC: begin
                    // Only a right-to-left transition gives a clean frame start.
                    if (prevWs_q && !WS) begin
                        state_q  <= LEFT;
                        locked_q <= 1'b1;
                    end
                end
                LEFT: begin
                    if (boundary && !prevWs_q) begin
                        leftHold_q <= word_d;
                        state_q    <= RIGHT;
                    end
                end
                RIGHT: begin
                    if (boundary && prevWs_q) begin
                        rxData_q <= {leftHold_q, word_d};
                        valid_q  <= 1'b1;
                        state_q  <= LEFT;
                    end
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase

`ifdef FRAME_ERR_EN
            // bitCnt_q counts bits before the boundary bit and saturates at
            // WIDTH, so exactly WIDTH-1 here means the word is the right length.
            frameErr_q <= boundary && (state_q != SYNC) && (bitCnt_q != CNT_LAST);
`endif
        end
    end

    assign RxData    = rxData_q;
    assign LeftData  = rxData_q[2*WIDTH-1:WIDTH];
    assign RightData = rxData_q[WIDTH-1:0];
    assign Valid     = valid_q;
    assign Locked    = locked_q;
`ifdef FRAME_ERR_EN
    assign FrameError = frameErr_q;
`else
    assign FrameError = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// ---------------------------------------------------------------------------
// tb_i2s_receiver
//
// Drives I2S streams into i2s_receiver (WIDTH=8) from the transmitter's point
// of view: words are listed as (channel, bit) pairs and WS leads the data by
// one bit. The expected outputs come from slicing the raw WS/data sequence
// at WS transitions into channel words and pairing them into frames.
// ---------------------------------------------------------------------------
module tb_i2s_receiver;

    localparam int W = 8;

    logic           SCK = 1'b0;
    logic           reset;
    logic           SerialData;
    logic           WS;
    logic [2*W-1:0] RxData;
    logic [W-1:0]   LeftData;
    logic [W-1:0]   RightData;
    logic           Valid;
    logic           Locked;
    logic           FrameError;

    int vectors     = 0;
    int miscompares = 0;

    // Transmitter-side word list, one entry per bit period.
    bit chanQ[$];
    bit bitQ[$];

    // Per-edge stimulus and expectations.
    bit             wsArr[$];
    bit             sdArr[$];
    bit             expValid[$];
    bit             expLocked[$];
    bit             expErr[$];
    logic [2*W-1:0] expData[$];

    int validEdges[$];
    int errCount;

    i2s_receiver #(.WIDTH(W)) dut (
        .SCK        (SCK),
        .reset      (reset),
        .SerialData (SerialData),
        .WS         (WS),
        .RxData     (RxData),
        .LeftData   (LeftData),
        .RightData  (RightData),
        .Valid      (Valid),
        .Locked     (Locked),
        .FrameError (FrameError)
    );

    always #5 SCK = ~SCK;

    // One comparison: counts it, and reports a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input bit chan, input logic [15:0] value, input int len);
        for (int j = len - 1; j >= 0; j--) begin
            chanQ.push_back(chan);
            bitQ.push_back(((value >> j) & 16'd1) != 16'd0);
        end
    endtask

    task automatic pushFrame(input logic [15:0] l, input int ll, input logic [15:0] r, input int rl);
        pushWord(1'b0, l, ll);
        pushWord(1'b1, r, rl);
    endtask

    // New stream beginning with the LSB of an (ignored) right word.
    task automatic startStream(input bit leadIn);
        chanQ.delete();
        bitQ.delete();
        if (leadIn) pushWord(1'b1, 16'($urandom), 1);
    endtask

    // WS on each edge announces the channel of the following bit; after the
    // last bit the line returns to left so the final frame closes.
    task automatic buildEdges(input int limit);
        int n;
        n = bitQ.size();
        if (limit >= 0 && limit < n) n = limit;
        wsArr.delete();
        sdArr.delete();
        for (int i = 0; i < n; i++) begin
            sdArr.push_back(bitQ[i]);
            wsArr.push_back((i + 1 < bitQ.size()) ? chanQ[i + 1] : 1'b0);
        end
    endtask

    // Bits s..e (inclusive), MSB first, first W kept, zero padded.
    function automatic logic [W-1:0] sliceWord(input int s, input int e);
        logic [W-1:0] w;
        w = '0;
        for (int j = 0; j < W; j++) begin
            w = {w[W-2:0], (s + j <= e) ? sdArr[s + j] : 1'b0};
        end
        return w;
    endfunction

    task automatic buildExpected();
        int             n;
        int             lockIdx;
        int             start;
        bit             endsRight;
        bit             prev;
        logic [W-1:0]   leftW;
        logic [W-1:0]   w;
        logic [2*W-1:0] cur;
        n         = wsArr.size();
        lockIdx   = -1;
        endsRight = 1'b0;
        leftW     = '0;
        expValid.delete();
        expLocked.delete();
        expErr.delete();
        expData.delete();
        for (int i = 0; i < n; i++) begin
            expValid.push_back(1'b0);
            expLocked.push_back(1'b0);
            expErr.push_back(1'b0);
            expData.push_back('0);
        end
        for (int i = 0; i < n; i++) begin
            prev = (i == 0) ? 1'b1 : wsArr[i - 1];
            if (prev && !wsArr[i]) begin
                lockIdx = i;
                break;
            end
        end
        if (lockIdx >= 0) begin
            start = lockIdx;
            for (int b = lockIdx + 1; b < n; b++) begin
                if (wsArr[b] != wsArr[b - 1]) begin
                    w = sliceWord(start + 1, b);
`ifdef FRAME_ERR_EN
                    expErr[b] = ((b - start) != W);
`endif
                    if (!endsRight) begin
                        leftW = w;
                    end else begin
                        expValid[b] = 1'b1;
                        expData[b]  = {leftW, w};
                    end
                    endsRight = !endsRight;
                    start     = b;
                end
            end
        end
        cur = '0;
        for (int i = 0; i < n; i++) begin
            expLocked[i] = (lockIdx >= 0) && (i >= lockIdx);
            if (expValid[i]) cur = expData[i];
            expData[i] = cur;
        end
    endtask

    task automatic resetDut(input string name);
        @(negedge SCK);
        reset      = 1'b1;
        WS         = 1'($urandom);
        SerialData = 1'($urandom);
        @(posedge SCK);
        @(posedge SCK);
        @(negedge SCK);
        checkOutput({name, "/rst.RxData"}, 32'(RxData), 32'd0);
        checkOutput({name, "/rst.Valid"}, 32'(Valid), 32'd0);
        checkOutput({name, "/rst.Locked"}, 32'(Locked), 32'd0);
        checkOutput({name, "/rst.FrameError"}, 32'(FrameError), 32'd0);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input string name);
        for (int i = 0; i < wsArr.size(); i++) begin
            WS         = wsArr[i];
            SerialData = sdArr[i];
            @(posedge SCK);
            @(negedge SCK);
            checkOutput({name, "/Valid"}, 32'(Valid), 32'(expValid[i]));
            checkOutput({name, "/Locked"}, 32'(Locked), 32'(expLocked[i]));
            checkOutput({name, "/FrameError"}, 32'(FrameError), 32'(expErr[i]));
            checkOutput({name, "/RxData"}, 32'(RxData), 32'(expData[i]));
            if (expValid[i]) begin
                checkOutput({name, "/LeftData"}, 32'(LeftData), 32'(expData[i][2*W-1:W]));
                checkOutput({name, "/RightData"}, 32'(RightData), 32'(expData[i][W-1:0]));
            end
            if (Valid) validEdges.push_back(i);
            if (FrameError) errCount++;
        end
    endtask

    task automatic runSegment(input string name, input int limit);
        resetDut(name);
        buildEdges(limit);
        buildExpected();
        validEdges.delete();
        errCount = 0;
        applyStimulus(name);
    endtask

    initial begin
        reset      = 1'b1;
        WS         = 1'b1;
        SerialData = 1'b0;

        // Standard frames 0x8988, twice.
        startStream(1'b1);
        pushFrame(16'h89, 8, 16'h88, 8);
        pushFrame(16'h89, 8, 16'h88, 8);
        runSegment("std", -1);
        checkOutput("std.count", 32'(validEdges.size()), 32'd2);
        checkOutput("std.RxData", 32'(RxData), 32'h8988);
        checkOutput("std.Left", 32'(LeftData), 32'h89);
        checkOutput("std.Right", 32'(RightData), 32'h88);

        // Broken frame: lead-in plus five left bits, then reset.
        startStream(1'b1);
        pushFrame(16'h55, 8, 16'hAA, 8);
        runSegment("broken", 6);
        checkOutput("broken.count", 32'(validEdges.size()), 32'd0);
        startStream(1'b1);
        pushFrame(16'h12, 8, 16'h34, 8);
        runSegment("after", -1);
        checkOutput("after.count", 32'(validEdges.size()), 32'd1);
        checkOutput("after.RxData", 32'(RxData), 32'h1234);

        // Stream joined mid-left, followed by a full frame.
        startStream(1'b0);
        pushWord(1'b0, 16'($urandom), 3);
        pushWord(1'b1, 16'($urandom), 8);
        pushFrame(16'hC3, 8, 16'h3C, 8);
        runSegment("midleft", -1);
        checkOutput("midleft.RxData", 32'(RxData), 32'hC33C);

        // Back-to-back frames.
        startStream(1'b1);
        pushFrame(16'hA5, 8, 16'h5A, 8);
        pushFrame(16'hFF, 8, 16'hFF, 8);
        pushFrame(16'h00, 8, 16'h01, 8);
        runSegment("b2b", -1);
        checkOutput("b2b.count", 32'(validEdges.size()), 32'd3);
        if (validEdges.size() == 3) begin
            checkOutput("b2b.gap1", 32'(validEdges[1] - validEdges[0]), 32'd16);
            checkOutput("b2b.gap2", 32'(validEdges[2] - validEdges[1]), 32'd16);
        end
        checkOutput("b2b.RxData", 32'(RxData), 32'h0001);

        // Short left word (6 bits) and long right word (10 bits).
        startStream(1'b1);
        pushFrame(16'b101101, 6, 16'b1011010101, 10);
        runSegment("len", -1);
        checkOutput("len.Left", 32'(LeftData), 32'hB4);
        checkOutput("len.Right", 32'(RightData), 32'hB5);
`ifdef FRAME_ERR_EN
        checkOutput("len.errors", 32'(errCount), 32'd2);
`else
        checkOutput("len.errors", 32'(errCount), 32'd0);
`endif

        // Random words of 1..10 bits, including single-bit words.
        startStream(1'b1);
        for (int f = 0; f < 12; f++) begin
            pushFrame(16'($urandom), $urandom_range(1, 10), 16'($urandom), $urandom_range(1, 10));
        end
        runSegment("rand", -1);
        checkOutput("rand.count", 32'(validEdges.size()), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
